// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART debug command engine:
// host command codes, FSM state encoding and the read-error reply byte.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_HALT  = 8'h00;
    localparam logic [7:0] CMD_RUN   = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

    localparam logic [7:0] DEF_ERR_BYTE = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA,
        ST_BUS_WAIT,
        ST_TX_ARM,
        ST_TX_WAIT
    } state_t;

endpackage

// File: rtl/uart_cmd_decoder.sv
// UART debug command engine: parses host bytes into CPU halt/run
// control and single memory bus reads/writes, replying to reads over UART.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned BUS_TIMEOUT    = 64,
    parameter logic [7:0]  ERR_BYTE       = DEF_ERR_BYTE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_active,
    input  logic        tx_done,
    output logic        cpu_halt,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    output logic        cmd_err,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(BUS_TIMEOUT + 1);

    localparam logic [TW-1:0] BYTE_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] BUS_LAST  = BW'(BUS_TIMEOUT - 1);

    state_t        state;
    logic [TW-1:0] byte_tmr;
    logic [BW-1:0] bus_tmr;
    logic          in_cmd;
    logic          byte_expired;

    assign in_cmd = (state == ST_ADDR_HI) ||
                    (state == ST_ADDR_LO) ||
                    (state == ST_DATA);

    // An arriving byte always beats an expiring inter-byte timer.
    assign byte_expired = in_cmd && !rx_valid && (byte_tmr == BYTE_LAST);

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            byte_tmr  <= '0;
            bus_tmr   <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            cpu_halt  <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            cmd_err   <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            cmd_err  <= 1'b0;
            bus_tmr  <= '0;

            if (in_cmd && !rx_valid && !byte_expired) begin
                byte_tmr <= byte_tmr + TW'(1);
            end else begin
                byte_tmr <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_HALT: cpu_halt <= 1'b1;
                            CMD_RUN:  cpu_halt <= 1'b0;
                            CMD_WRITE, CMD_READ: begin
                                bus_we <= (rx_data == CMD_WRITE);
                                state  <= ST_ADDR_HI;
                            end
                            default:  cmd_err <= 1'b1;
                        endcase
                    end
                end

                ST_ADDR_HI: begin
                    if (rx_valid) begin
                        bus_addr[15:8] <= rx_data;
                        state          <= ST_ADDR_LO;
                    end
                end

                ST_ADDR_LO: begin
                    if (rx_valid) begin
                        bus_addr[7:0] <= rx_data;
                        if (bus_we) begin
                            state <= ST_DATA;
                        end else begin
                            bus_req <= 1'b1;
                            state   <= ST_BUS_WAIT;
                        end
                    end
                end

                ST_DATA: begin
                    if (rx_valid) begin
                        bus_wdata <= rx_data;
                        bus_req   <= 1'b1;
                        state     <= ST_BUS_WAIT;
                    end
                end

                ST_BUS_WAIT: begin
                    if (rx_valid) begin
                        cmd_err <= 1'b1;
                    end
                    // A late ack on the expiry cycle still completes cleanly.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (bus_we) begin
                            state <= ST_IDLE;
                        end else begin
                            tx_data <= bus_rdata;
                            state   <= ST_TX_ARM;
                        end
                    end else if (bus_tmr == BUS_LAST) begin
                        bus_req <= 1'b0;
                        cmd_err <= 1'b1;
                        if (bus_we) begin
                            state <= ST_IDLE;
                        end else begin
                            tx_data <= ERR_BYTE;
                            state   <= ST_TX_ARM;
                        end
                    end else begin
                        bus_tmr <= bus_tmr + BW'(1);
                    end
                end

                ST_TX_ARM: begin
                    if (rx_valid) begin
                        cmd_err <= 1'b1;
                    end
                    if (!tx_active) begin
                        tx_start <= 1'b1;
                        state    <= ST_TX_WAIT;
                    end
                end

                ST_TX_WAIT: begin
                    if (rx_valid) begin
                        cmd_err <= 1'b1;
                    end
                    if (tx_done) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase

            if (byte_expired) begin
                state   <= ST_IDLE;
                cmd_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: randomized host commands
// against a reference memory image, bus slave and UART transmitter models.
module tb_uart_cmd_decoder;
    import uart_cmd_pkg::*;

    localparam int TO = 100;
    localparam int BT = 64;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_active;
    logic        tx_done;
    logic        cpu_halt;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ack;
    logic [7:0]  bus_rdata;
    logic        cmd_err;
    logic        busy;

    uart_cmd_decoder #(
        .TIMEOUT_CYCLES(TO),
        .BUS_TIMEOUT   (BT),
        .ERR_BYTE      (8'hEE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_active(tx_active),
        .tx_done  (tx_done),
        .cpu_halt (cpu_halt),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata),
        .cmd_err  (cmd_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [0:65535];
    logic [7:0] bus_mem [0:65535];
    bit         halt_ref  = 1'b0;
    bit         rand_gaps = 1'b0;

    // Bus slave model
    bit ack_en    = 1'b1;
    int ack_delay = 2;
    int ack_wait  = 0;
    bit ack_given = 1'b0;

    always @(negedge clk) begin
        bus_ack = 1'b0;
        if (!bus_req) begin
            ack_wait  = 0;
            ack_given = 1'b0;
        end else if (ack_en && !ack_given) begin
            if (ack_wait >= ack_delay) begin
                bus_ack   = 1'b1;
                ack_given = 1'b1;
                if (bus_we) begin
                    bus_mem[bus_addr] = bus_wdata;
                    bus_rdata = 8'($urandom);
                end else begin
                    bus_rdata = bus_mem[bus_addr];
                end
            end else begin
                ack_wait++;
            end
        end
    end

    // UART transmitter model
    bit         sending     = 1'b0;
    bit         hold_active = 1'b0;
    int         tx_cyc      = 0;
    int         tx_starts   = 0;
    int         tx_unstable = 0;
    int         tx_overlap  = 0;
    logic [7:0] last_tx     = '0;

    always @(negedge clk) begin
        tx_done = 1'b0;
        if (sending) begin
            if (tx_data !== last_tx) tx_unstable++;
            if (tx_cyc == 3) begin
                tx_done = 1'b1;
                sending = 1'b0;
            end else begin
                tx_cyc++;
            end
        end
        if (tx_start === 1'b1) begin
            if (tx_active) tx_overlap++;
            tx_starts++;
            last_tx = tx_data;
            sending = 1'b1;
            tx_cyc  = 0;
        end
        tx_active = sending | hold_active;
    end

    // Bus / error monitor
    bit          prev_req = 1'b0;
    int          req_cnt  = 0;
    int          req_unstable = 0;
    int          cur_len  = 0;
    int          last_len = 0;
    int          err_cnt  = 0;
    logic [15:0] cap_addr = '0;
    logic        cap_we   = 1'b0;
    logic [7:0]  cap_wdata = '0;

    always @(negedge clk) begin
        if (bus_req === 1'b1) begin
            if (!prev_req) begin
                req_cnt++;
                cap_addr  = bus_addr;
                cap_we    = bus_we;
                cap_wdata = bus_wdata;
                cur_len   = 0;
            end else if ({bus_addr, bus_we, bus_wdata} !==
                         {cap_addr, cap_we, cap_wdata}) begin
                req_unstable++;
            end
            cur_len++;
        end else if (prev_req) begin
            last_len = cur_len;
        end
        if (cmd_err === 1'b1) err_cnt++;
        prev_req = (bus_req === 1'b1);
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        if (rand_gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        timed_out = (busy !== 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_start, tx_data, cpu_halt, bus_req, bus_we, bus_addr,
             bus_wdata, cmd_err, busy} !== '0) begin
            errors++;
            $display("FAIL reset: outputs=%h, required all zero",
                     {tx_start, tx_data, cpu_halt, bus_req, bus_we,
                      bus_addr, bus_wdata, cmd_err, busy});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_halt(input bit h);
        send_byte(h ? CMD_HALT : CMD_RUN);
        halt_ref = h;
        checks++;
        if (cpu_halt !== halt_ref || busy !== 1'b0) begin
            errors++;
            $display("FAIL halt_run: cpu_halt=%b busy=%b, required %b 0",
                     cpu_halt, busy, halt_ref);
        end
    endtask

    task automatic test_halt();
        do_halt(1'b1);
        do_halt(1'b0);
    endtask

    task automatic test_write(input logic [15:0] a, input logic [7:0] d);
        int r0 = req_cnt;
        int t0 = tx_starts;
        int e0 = err_cnt;
        bit to;
        send_byte(CMD_WRITE);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(d);
        ref_mem[a] = d;
        wait_idle(BT + 10, to);
        checks++;
        if (to || req_cnt != r0 + 1 || cap_we !== 1'b1 ||
            cap_addr !== a || cap_wdata !== d) begin
            errors++;
            $display("FAIL write: to=%b reqs=%0d we=%b addr=%h wd=%h, required reqs=%0d we=1 addr=%h wd=%h",
                     to, req_cnt - r0, cap_we, cap_addr, cap_wdata, 1, a, d);
        end
        checks++;
        if (tx_starts != t0 || err_cnt != e0) begin
            errors++;
            $display("FAIL write_side: tx_starts=%0d errs=%0d, required 0 0",
                     tx_starts - t0, err_cnt - e0);
        end
    endtask

    task automatic test_read(input logic [15:0] a, input bit pre_active);
        int r0 = req_cnt;
        int t0 = tx_starts;
        int e0 = err_cnt;
        bit to;
        if (pre_active) begin
            hold_active = 1'b1;
            @(negedge clk);
        end
        send_byte(CMD_READ);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        if (pre_active) begin
            repeat (12) @(negedge clk);
            checks++;
            if (tx_starts != t0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL read_tx_held: tx_starts=%0d busy=%b, required 0 1",
                         tx_starts - t0, busy);
            end
            hold_active = 1'b0;
        end
        wait_idle(BT + 40, to);
        checks++;
        if (to || req_cnt != r0 + 1 || cap_we !== 1'b0 || cap_addr !== a) begin
            errors++;
            $display("FAIL read_bus: to=%b reqs=%0d we=%b addr=%h, required 1 0 %h",
                     to, req_cnt - r0, cap_we, cap_addr, a);
        end
        checks++;
        if (tx_starts != t0 + 1 || last_tx !== ref_mem[a] || err_cnt != e0) begin
            errors++;
            $display("FAIL read_reply: tx_starts=%0d data=%h errs=%0d, required 1 %h 0",
                     tx_starts - t0, last_tx, err_cnt - e0, ref_mem[a]);
        end
    endtask

    task automatic test_spec_examples();
        rand_gaps = 1'b0;
        ack_delay = 2;
        test_write(16'h2006, 8'h3F);
        ref_mem[16'h2007] = 8'hA5;
        bus_mem[16'h2007] = 8'hA5;
        test_read(16'h2007, 1'b0);
        test_read(16'h2007, 1'b1);
    endtask

    task automatic test_bad_cmd();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            int e0 = err_cnt;
            int r0 = req_cnt;
            b = (i == 0) ? 8'h7F : 8'($urandom_range(4, 255));
            send_byte(b);
            @(negedge clk);
            checks++;
            if (err_cnt != e0 + 1 || busy !== 1'b0 ||
                cpu_halt !== halt_ref || req_cnt != r0) begin
                errors++;
                $display("FAIL bad_cmd %h: errs=%0d busy=%b halt=%b reqs=%0d, required 1 0 %b 0",
                         b, err_cnt - e0, busy, cpu_halt, req_cnt - r0, halt_ref);
            end
        end
    endtask

    task automatic test_cmd_timeout();
        int e0;
        int r0;
        bit to;
        rand_gaps = 1'b0;
        send_byte(CMD_WRITE);
        send_byte(8'h20);
        e0 = err_cnt;
        r0 = req_cnt;
        repeat (TO - 10) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || err_cnt != e0) begin
            errors++;
            $display("FAIL cmd_timeout_early: busy=%b errs=%0d, required 1 0",
                     busy, err_cnt - e0);
        end
        wait_idle(20, to);
        checks++;
        if (to || err_cnt != e0 + 1 || req_cnt != r0) begin
            errors++;
            $display("FAIL cmd_timeout: to=%b errs=%0d reqs=%0d, required 0 1 0",
                     to, err_cnt - e0, req_cnt - r0);
        end
        test_read(16'h0000, 1'b0);
    endtask

    task automatic test_bus_timeout();
        int e0 = err_cnt;
        int t0 = tx_starts;
        bit to;
        rand_gaps = 1'b0;
        ack_en = 1'b0;
        send_byte(CMD_READ);
        send_byte(8'h40);
        send_byte(8'h01);
        wait_idle(BT + 40, to);
        checks++;
        if (to || last_len != BT || err_cnt != e0 + 1 ||
            tx_starts != t0 + 1 || last_tx !== 8'hEE) begin
            errors++;
            $display("FAIL bus_timeout_rd: to=%b req_len=%0d errs=%0d txs=%0d data=%h, required 0 %0d 1 1 ee",
                     to, last_len, err_cnt - e0, tx_starts - t0, last_tx, BT);
        end
        e0 = err_cnt;
        t0 = tx_starts;
        send_byte(CMD_WRITE);
        send_byte(8'h40);
        send_byte(8'h01);
        send_byte(~ref_mem[16'h4001]);
        wait_idle(BT + 40, to);
        checks++;
        if (to || last_len != BT || err_cnt != e0 + 1 || tx_starts != t0) begin
            errors++;
            $display("FAIL bus_timeout_wr: to=%b req_len=%0d errs=%0d txs=%0d, required 0 %0d 1 0",
                     to, last_len, err_cnt - e0, tx_starts - t0, BT);
        end
        ack_en = 1'b1;
        test_read(16'h4001, 1'b0);
    endtask

    task automatic test_rx_during_bus();
        int e0 = err_cnt;
        int r0 = req_cnt;
        int t0 = tx_starts;
        bit to;
        rand_gaps = 1'b0;
        ack_delay = 8;
        send_byte(CMD_READ);
        send_byte(8'h20);
        send_byte(8'h06);
        repeat (2) @(negedge clk);
        send_byte(CMD_WRITE);
        wait_idle(BT + 40, to);
        checks++;
        if (to || err_cnt != e0 + 1 || req_cnt != r0 + 1 ||
            cap_addr !== 16'h2006 || tx_starts != t0 + 1 ||
            last_tx !== ref_mem[16'h2006]) begin
            errors++;
            $display("FAIL rx_during_bus: to=%b errs=%0d reqs=%0d addr=%h txs=%0d data=%h, required 0 1 1 2006 1 %h",
                     to, err_cnt - e0, req_cnt - r0, cap_addr,
                     tx_starts - t0, last_tx, ref_mem[16'h2006]);
        end
        ack_delay = 2;
    endtask

    task automatic test_back_to_back();
        rand_gaps = 1'b0;
        ack_delay = 0;
        for (int i = 0; i < 3; i++) begin
            logic [15:0] a;
            a = 16'($urandom);
            test_write(a, 8'($urandom));
            test_read(a, 1'b0);
        end
        ack_delay = 2;
    endtask

    task automatic test_reset_mid_read();
        int t0;
        rand_gaps = 1'b0;
        do_halt(1'b1);
        ack_en = 1'b0;
        send_byte(CMD_READ);
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (3) @(negedge clk);
        checks++;
        if (bus_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre: bus_req=%b busy=%b, required 1 1",
                     bus_req, busy);
        end
        t0 = tx_starts;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_start, tx_data, cpu_halt, bus_req, bus_we, bus_addr,
             bus_wdata, cmd_err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid: outputs=%h, required all zero",
                     {tx_start, tx_data, cpu_halt, bus_req, bus_we,
                      bus_addr, bus_wdata, cmd_err, busy});
        end
        rst = 1'b0;
        halt_ref = 1'b0;
        ack_en = 1'b1;
        repeat (BT + 20) @(negedge clk);
        checks++;
        if (tx_starts != t0 || bus_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: txs=%0d bus_req=%b busy=%b, required 0 0 0",
                     tx_starts - t0, bus_req, busy);
        end
    endtask

    task automatic test_random();
        rand_gaps = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            a = 16'h2000 + 16'($urandom_range(0, 7));
            ack_delay = $urandom_range(0, 4);
            case ($urandom_range(0, 5))
                0:       do_halt(1'b1);
                1:       do_halt(1'b0);
                2, 3:    test_write(a, 8'($urandom));
                default: test_read(a, $urandom_range(0, 3) == 0);
            endcase
            checks++;
            if (cpu_halt !== halt_ref) begin
                errors++;
                $display("FAIL random_halt: cpu_halt=%b, required %b",
                         cpu_halt, halt_ref);
            end
        end
        rand_gaps = 1'b0;
        ack_delay = 2;
    endtask

    task automatic test_protocol();
        checks++;
        if (req_unstable != 0 || tx_unstable != 0 || tx_overlap != 0) begin
            errors++;
            $display("FAIL protocol: req_unstable=%0d tx_unstable=%0d tx_overlap=%0d, required 0 0 0",
                     req_unstable, tx_unstable, tx_overlap);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        tx_done   = 1'b0;
        tx_active = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            ref_mem[i] = 8'((i * 7) ^ (i >> 8));
            bus_mem[i] = 8'((i * 7) ^ (i >> 8));
        end
        @(negedge clk);
        test_reset();
        test_halt();
        test_spec_examples();
        test_bad_cmd();
        test_cmd_timeout();
        test_bus_timeout();
        test_rx_during_bus();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
